encoder83_sync: RTL

- Registered 8-to-3 priority encoder with debounce. It is the receive-side counterpart of the team's 3-to-8 select decoder.
- Takes eight select/request lines of configurable polarity, synchronises them and requires a stable pattern before reporting. It returns the 3-bit index with a valid/ack handshake.
- Sits between external one-hot select or keypad lines and the control logic that consumes a line index.

---
 rtl/encoder83_sync_if.sv | 30 +++
 rtl/encoder83_sync.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/encoder83_sync_if.sv
// ---------------------------------------------------------------------------
// encoder83_sync_if: request/report bundle for the registered 8-to-3 encoder.
//   i_y     [7:0] request lines (asynchronous to the encoder clock)
//   i_opt         line polarity, 0 = active-low, 1 = active-high
//   i_ack         consumer accepts the reported code
//   o_sel   [2:0] index of the lowest-numbered active line
//   o_valid       o_sel/o_multi hold a new accepted code
//   o_multi       more than one line was active in the accepted pattern
//   o_busy        encoder is not idle
// master = line source / consumer side, slave = encoder side.
// ---------------------------------------------------------------------------
interface encoder83_sync_if;
   logic [7:0] i_y;
   logic       i_opt;
   logic       i_ack;
   logic [2:0] o_sel;
   logic       o_valid;
   logic       o_multi;
   logic       o_busy;

   modport master (
      output i_y, i_opt, i_ack,
      input  o_sel, o_valid, o_multi, o_busy
   );

   modport slave (
      input  i_y, i_opt, i_ack,
      output o_sel, o_valid, o_multi, o_busy
   );
endinterface

// File: rtl/encoder83_sync.sv
// ---------------------------------------------------------------------------
// encoder83_sync: debounced, registered 8-to-3 priority encoder.
// Request lines are polarity-normalised, double-flop synchronised and must
// hold an identical non-zero pattern for STABLE_CNT samples before the index
// of the lowest active line is reported with a valid/ack handshake. After an
// ack, STABLE_CNT all-inactive samples are needed before re-arming, so a held
// key reports once.
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    encoder83_sync_if.slave (i_y, i_opt, i_ack -> o_sel, o_valid,
//          o_multi, o_busy; all outputs registered)
// ---------------------------------------------------------------------------
module encoder83_sync #(
   parameter int unsigned STABLE_CNT = 4,
   parameter int unsigned CNT_W      = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   encoder83_sync_if.slave  bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CHECK   = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic [7:0]       act_raw;
   logic [7:0]       s1_q, act_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       cand_q, cand_d;
   logic [2:0]       sel_q, sel_d;
   logic             multi_q, multi_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   // Index of the lowest set bit; the loop runs high to low so bit 0 wins.
   function automatic logic [2:0] enc_low(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Clearing the lowest set bit leaves something only if two or more were set.
   function automatic logic multi_bits(input logic [7:0] v);
      return (v & (v - 8'd1)) != 8'd0;
   endfunction

   // Polarity normalisation ahead of the synchroniser: 1 = line active.
   assign act_raw = bus.i_opt ? bus.i_y : ~bus.i_y;

   // Two-flop synchroniser, reset to "no line active".
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_q  <= 8'h00;
         act_q <= 8'h00;
      end else begin
         s1_q  <= act_raw;
         act_q <= s1_q;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      sel_d   = sel_q;
      multi_d = multi_q;
      valid_d = valid_q;

      case (state_q)
         ST_IDLE: begin
            if (act_q != 8'h00) begin
               cand_d  = act_q;
               cnt_d   = CNT_ONE;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (act_q == cand_q) begin
               if (cnt_q == CNT_LAST) begin
                  sel_d   = enc_low(cand_q);
                  multi_d = multi_bits(cand_q);
                  valid_d = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else if (act_q != 8'h00) begin
               // New pattern restarts the stability run.
               cand_d = act_q;
               cnt_d  = CNT_ONE;
            end else begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            // Reported code is frozen here; only the ack matters.
            if (bus.i_ack) begin
               valid_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            // Any active sample restarts the all-inactive run.
            if (act_q == 8'h00) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               cnt_d = '0;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cand_q  <= 8'h00;
         sel_q   <= 3'd0;
         multi_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         sel_q   <= sel_d;
         multi_q <= multi_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.o_sel   = sel_q;
   assign bus.o_valid = valid_q;
   assign bus.o_multi = multi_q;
   assign bus.o_busy  = busy_q;

endmodule
